// File: rtl/gpin_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : gpin_conditioner
//  Function : 16-bit input conditioner: 2-flop synchroniser followed by an
//             optional per-bit tick-based debounce (GPIN_CONDITIONER_DEBOUNCE_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module gpin_conditioner #(
    parameter int PRESCALE     = 1000,
    parameter int STABLE_TICKS = 4
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [15:0] PIN_I,
    output logic [15:0] PORT_O,
    output logic [15:0] CHG_O
);

    logic [15:0] r_s1;
    logic [15:0] r_s2;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= PIN_I;
            r_s2 <= r_s1;
        end
    end

`ifdef GPIN_CONDITIONER_DEBOUNCE_EN
    localparam int c_PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int c_CNT_W   = $clog2(STABLE_TICKS + 1);
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(PRESCALE - 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_LAST   = c_CNT_W'(STABLE_TICKS - 1);

    logic [c_PRESC_W-1:0] r_presc;
    logic                 w_tick;
    logic [15:0]          w_port;
    logic [15:0]          w_chg;

    // With PRESCALE = 1 the counter is pinned at 0 and w_tick is constant high.
    assign w_tick = (r_presc == c_PRESC_LAST);

    always_ff @(posedge CLK_I) begin
        if (RST_I || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_bit
        logic [c_CNT_W-1:0] r_cnt;
        logic               r_port;
        logic               r_chg;

        always_ff @(posedge CLK_I) begin
            if (RST_I) begin
                r_cnt  <= '0;
                r_port <= 1'b0;
                r_chg  <= 1'b0;
            end else begin
                r_chg <= 1'b0;
                if (r_s2[i] == r_port) begin
                    r_cnt <= '0;
                end else if (w_tick) begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_port <= r_s2[i];
                        r_cnt  <= '0;
                        r_chg  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
        end

        assign w_port[i] = r_port;
        assign w_chg[i]  = r_chg;
    end

    assign PORT_O = w_port;
    assign CHG_O  = w_chg;
`else
    logic [15:0] r_port;
    logic [15:0] r_chg;
    logic        w_unused_params;

    // Timing parameters have no meaning without the debounce stage.
    assign w_unused_params = |{PRESCALE, STABLE_TICKS};

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_port <= '0;
            r_chg  <= '0;
        end else begin
            r_port <= r_s2;
            r_chg  <= r_s2 ^ r_port;
        end
    end

    assign PORT_O = r_port;
    assign CHG_O  = r_chg;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gpin_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpin_conditioner
//  Function : directed vector table plus debounce corner sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gpin_conditioner;

    typedef struct {
        logic        rst;
        logic [15:0] pin;
        logic [15:0] port;
        logic [15:0] chg;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pin;
    logic [15:0] port_a, chg_a;
    logic [15:0] port_b, chg_b;
    int          n_checks = 0;
    int          n_errors = 0;
    vec_t        tbl [20];

    always #5 clk = ~clk;

    gpin_conditioner #(.PRESCALE(4), .STABLE_TICKS(3)) dut (
        .CLK_I (clk),
        .RST_I (rst),
        .PIN_I (pin),
        .PORT_O(port_a),
        .CHG_O (chg_a)
    );

    gpin_conditioner #(.PRESCALE(1), .STABLE_TICKS(1)) u_fast (
        .CLK_I (clk),
        .RST_I (rst),
        .PIN_I (pin),
        .PORT_O(port_b),
        .CHG_O (chg_b)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Acceptance for the 4/3 instance lands on edge 12 after reset release
    // (ticks at edges 4, 8, 12; mismatch first visible at edge 3).
    task automatic run_accept(input string name, input logic [15:0] val);
        do_reset();
        pin = val;
        for (int k = 1; k <= 14; k++) begin
            step();
            check($sformatf("%s port k=%0d", name, k), port_a, (k >= 12) ? val : 16'h0000);
            check($sformatf("%s chg k=%0d", name, k), chg_a, (k == 12) ? val : 16'h0000);
        end
    endtask

    initial begin
        tbl[0]  = '{1'b0, 16'h8001, 16'h0000, 16'h0000};
        tbl[1]  = '{1'b0, 16'h8001, 16'h0000, 16'h0000};
        tbl[2]  = '{1'b0, 16'h8001, 16'h8001, 16'h8001};
        tbl[3]  = '{1'b0, 16'h8001, 16'h8001, 16'h0000};
        tbl[4]  = '{1'b0, 16'h0000, 16'h8001, 16'h0000};
        tbl[5]  = '{1'b0, 16'hA5A5, 16'h8001, 16'h0000};
        tbl[6]  = '{1'b0, 16'hA5A5, 16'h0000, 16'h8001};
        tbl[7]  = '{1'b0, 16'hA5A5, 16'hA5A5, 16'hA5A5};
        tbl[8]  = '{1'b0, 16'hA5A5, 16'hA5A5, 16'h0000};
        tbl[9]  = '{1'b0, 16'hA5B5, 16'hA5A5, 16'h0000};
        tbl[10] = '{1'b0, 16'hA5A5, 16'hA5A5, 16'h0000};
        tbl[11] = '{1'b0, 16'hA5A5, 16'hA5B5, 16'h0010};
        tbl[12] = '{1'b0, 16'hA5A5, 16'hA5A5, 16'h0010};
        tbl[13] = '{1'b0, 16'hA5A5, 16'hA5A5, 16'h0000};
        tbl[14] = '{1'b0, 16'h0000, 16'hA5A5, 16'h0000};
        tbl[15] = '{1'b1, 16'hFFFF, 16'h0000, 16'h0000};
        tbl[16] = '{1'b0, 16'hFFFF, 16'h0000, 16'h0000};
        tbl[17] = '{1'b0, 16'hFFFF, 16'h0000, 16'h0000};
        tbl[18] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        tbl[19] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'h0000};

        rst = 1'b1;
        pin = 16'h0000;
        step();
        step();
        check("reset port_a", port_a, 16'h0000);
        check("reset chg_a",  chg_a,  16'h0000);
        check("reset port_b", port_b, 16'h0000);
        check("reset chg_b",  chg_b,  16'h0000);
        rst = 1'b0;

        // Without debounce both instances are pure 3-stage pipelines; the
        // 1/1 debounce instance accepts on every edge and matches them too.
        for (int i = 0; i < 20; i++) begin
            rst = tbl[i].rst;
            pin = tbl[i].pin;
            step();
            check($sformatf("vec%0d port_b", i), port_b, tbl[i].port);
            check($sformatf("vec%0d chg_b", i),  chg_b,  tbl[i].chg);
`ifndef GPIN_CONDITIONER_DEBOUNCE_EN
            check($sformatf("vec%0d port_a", i), port_a, tbl[i].port);
            check($sformatf("vec%0d chg_a", i),  chg_a,  tbl[i].chg);
`endif
        end
        rst = 1'b0;

`ifdef GPIN_CONDITIONER_DEBOUNCE_EN
        run_accept("single", 16'h0001);
        run_accept("multi", 16'hA5A5);

        // Short pulse: high for 5 samples, gone before the third tick.
        do_reset();
        pin = 16'h0001;
        for (int k = 1; k <= 20; k++) begin
            if (k == 6) pin = 16'h0000;
            step();
            check($sformatf("glitch port k=%0d", k), port_a, 16'h0000);
            check($sformatf("glitch chg k=%0d", k),  chg_a,  16'h0000);
        end

        // Reset one edge before acceptance, then full re-timing.
        do_reset();
        pin = 16'hFFFF;
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("abort port k=%0d", k), port_a, 16'h0000);
        end
        rst = 1'b1;
        step();
        check("abort port rst", port_a, 16'h0000);
        check("abort chg rst",  chg_a,  16'h0000);
        rst = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            step();
            check($sformatf("retime port k=%0d", k), port_a, (k >= 12) ? 16'hFFFF : 16'h0000);
            check($sformatf("retime chg k=%0d", k),  chg_a,  (k == 12) ? 16'hFFFF : 16'h0000);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gpin_conditioner.md
GPIN_CONDITIONER -- requirements
Module: gpin_conditioner

Interface
REQ-001 Parameter PRESCALE, default 1000, clock cycles per debounce tick; legal range >= 1.
REQ-002 Parameter STABLE_TICKS, default 4, consecutive ticks an input must differ before acceptance; legal range >= 1.
REQ-003 CLK_I  input  1  sole clock; all state updates on its rising edge.
REQ-004 RST_I  input  1  synchronous, active-high reset.
REQ-005 PIN_I  input  16  raw asynchronous external pins.
REQ-006 PORT_O  output  16  conditioned pin levels; drives the GPIA PORT_I input directly.
REQ-007 CHG_O  output  16  per-bit one-cycle pulse, asserted in the cycle the matching PORT_O bit changes.

Function
REQ-008 Each PIN_I bit SHALL pass through a two-flop synchronizer (s1, s2) before any other use.
REQ-009 One shared prescaler SHALL count 0..PRESCALE-1 and wrap to 0; tick is asserted while count == PRESCALE-1 (every cycle when PRESCALE = 1).
REQ-010 Each bit SHALL have an independent stability counter sized to hold STABLE_TICKS.
REQ-011 While s2[i] == PORT_O[i], counter i SHALL clear to 0 on every edge, regardless of tick.
REQ-012 While s2[i] != PORT_O[i] and tick is asserted, counter i SHALL increment.
REQ-013 When s2[i] != PORT_O[i], tick is asserted and counter i == STABLE_TICKS-1: PORT_O[i] <= s2[i], counter i <= 0 and CHG_O[i] <= 1 on the same edge.
REQ-014 CHG_O[i] SHALL be 0 in every cycle in which PORT_O[i] does not change; each pulse lasts exactly one cycle.
REQ-015 A mismatch that disappears before acceptance SHALL leave PORT_O[i] unchanged, clear counter i and produce no CHG_O pulse.
REQ-016 Bits SHALL act independently; simultaneous acceptances on several bits SHALL pulse all matching CHG_O bits in the same cycle.
REQ-017 Acceptance latency from a PIN_I edge (edge 0 = s1 sample) SHALL fall between edges (STABLE_TICKS-1)*PRESCALE+2 and STABLE_TICKS*PRESCALE+1 inclusive, depending on prescaler phase.
REQ-018 PORT_O and CHG_O SHALL be driven directly from registers, with no combinational path from PIN_I.

Reset
REQ-019 While RST_I is high on an edge: s1, s2, PORT_O, CHG_O, prescaler and all stability counters SHALL load 0.
REQ-020 Reset asserted mid-count SHALL abort all pending acceptances with no CHG_O pulse, including in the first cycle after release.
REQ-021 After release, a pin held high SHALL be accepted as a 0->1 change under the normal rules of REQ-013/REQ-017.

Configuration
REQ-022 Macro GPIN_CONDITIONER_DEBOUNCE_EN SHALL select the debounce logic.
REQ-023 Defined: behaviour SHALL follow REQ-009 to REQ-017.
REQ-024 Undefined: the prescaler and stability counters SHALL be omitted and PARAMETERS ignored; on every edge PORT_O <= s2 and CHG_O <= s2 ^ PORT_O, giving 3-edge latency from PIN_I to PORT_O with a matching CHG_O pulse; reset rules REQ-019/REQ-020 still apply.

Verification
REQ-025 Debounce on, PRESCALE=4, STABLE_TICKS=3, reset, then PIN_I=16'h0001 held -> PORT_O=16'h0001 after 10-13 edges; CHG_O=16'h0001 for exactly that one cycle.
REQ-026 Same parameters, PIN_I[0] high for 5 cycles then low -> PORT_O stays 16'h0000; CHG_O stays 0.
REQ-027 Same parameters, PIN_I 16'h0000->16'hA5A5 on one edge -> all eight bits change on the same edge; CHG_O=16'hA5A5 for one cycle.
REQ-028 Same parameters, PIN_I=16'hFFFF; assert RST_I one cycle before the expected acceptance -> PORT_O=0, CHG_O=0; after release, acceptance is re-timed from scratch per REQ-017.
REQ-029 PRESCALE=1, STABLE_TICKS=1, PIN_I[15] toggled -> PORT_O[15] follows at edge 2; a 1-cycle glitch on PIN_I is still accepted (documented minimum filtering).
REQ-030 Debounce off, PIN_I=16'h8001 -> PORT_O=16'h8001 at edge 2 (third edge), CHG_O=16'h8001 on that same edge only.
